// File: rtl/icb_sa_pkg.sv
// Shared types and helpers for the ICB slave-port arbiter.
// Holds the FSM state enum and the round-robin pick function used by the top.
package icb_sa_pkg;

    localparam int unsigned NUM_M_DEF = 2;
    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned DW        = WIDTH_DEF / 8;
    localparam int unsigned ID_W      = $clog2(NUM_M_DEF);
    localparam int unsigned MAX_M     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    // First requester at or after ptr, wrapping modulo n; returns 0 when none request.
    function automatic logic [2:0] rr_pick(input logic [MAX_M-1:0] req,
                                           input logic [2:0]       ptr,
                                           input int unsigned      n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_M; k++) begin
            idx = (32'(ptr) + k) % n;
            if (!found && (k < n) && req[idx[2:0]]) begin
                found = 1'b1;
                pick  = idx[2:0];
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/icb_id_fifo.sv
// In-flight ID FIFO: records which master issued each outstanding beat so
// responses can be routed back in order.
module icb_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/icb_sa_arbiter.sv
// Burst-granular round-robin arbiter sharing one ICB slave port between
// NUM_M masters, with in-order response routing through an ID FIFO.
module icb_sa_arbiter
    import icb_sa_pkg::*;
#(
    parameter int unsigned NUM_M     = 2,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned ICB_LEN_W = 3,
    parameter int unsigned OUTS      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_M-1:0]              m_cmd_valid_i,
    output logic [NUM_M-1:0]              m_cmd_ready_o,
    input  logic [NUM_M*ADDR_W-1:0]       m_cmd_addr_i,
    input  logic [NUM_M-1:0]              m_cmd_read_i,
    input  logic [NUM_M*WIDTH-1:0]        m_cmd_wdata_i,
    input  logic [NUM_M*(WIDTH/8)-1:0]    m_cmd_wmask_i,
    input  logic [NUM_M*ICB_LEN_W-1:0]    m_cmd_len_i,
    output logic [NUM_M-1:0]              m_rsp_valid_o,
    input  logic [NUM_M-1:0]              m_rsp_ready_i,
    output logic [WIDTH-1:0]              m_rsp_rdata_o,
    output logic                          m_rsp_err_o,
    output logic                          s_cmd_valid_o,
    input  logic                          s_cmd_ready_i,
    output logic [ADDR_W-1:0]             s_cmd_addr_o,
    output logic                          s_cmd_read_o,
    output logic [WIDTH-1:0]              s_cmd_wdata_o,
    output logic [(WIDTH/8)-1:0]          s_cmd_wmask_o,
    output logic [ICB_LEN_W-1:0]          s_cmd_len_o,
    input  logic                          s_rsp_valid_i,
    output logic                          s_rsp_ready_o,
    input  logic [WIDTH-1:0]              s_rsp_rdata_i,
    input  logic                          s_rsp_err_i
);

    localparam int unsigned DWL = WIDTH / 8;
    localparam int unsigned GW  = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    arb_state_e           state_q;
    logic [GW-1:0]        grant_q, rr_ptr_q;
    logic [ICB_LEN_W-1:0] len_q, beat_cnt_q;

    logic [MAX_M-1:0]     req_ext;
    logic [2:0]           pick;
    logic [GW-1:0]        gnt, gnt_nxt, head;
    int unsigned          gi;
    logic [ICB_LEN_W-1:0] cur_len;
    logic                 cmd_fire, rsp_fire;
    logic                 fifo_full, fifo_empty;

    // Grant is combinational in IDLE and locked to the burst owner in BURST.
    always_comb begin
        req_ext              = '0;
        req_ext[NUM_M-1:0]   = m_cmd_valid_i;
        pick                 = rr_pick(req_ext, 3'(rr_ptr_q), NUM_M);
        gnt                  = (state_q == BURST) ? grant_q : pick[GW-1:0];
        gnt_nxt              = (gnt == GW'(NUM_M - 1)) ? '0 : gnt + 1'b1;
        gi                   = 32'(gnt);
        cur_len              = m_cmd_len_i[gi*ICB_LEN_W +: ICB_LEN_W];
    end

    always_comb begin
        s_cmd_addr_o              = m_cmd_addr_i[gi*ADDR_W +: ADDR_W];
        s_cmd_read_o              = m_cmd_read_i[gi];
        s_cmd_wdata_o             = m_cmd_wdata_i[gi*WIDTH +: WIDTH];
        s_cmd_wmask_o             = m_cmd_wmask_i[gi*DWL +: DWL];
        s_cmd_len_o               = cur_len;
        s_cmd_valid_o             = !rst && m_cmd_valid_i[gi] && !fifo_full;
        m_cmd_ready_o             = '0;
        m_cmd_ready_o[gi]         = !rst && s_cmd_ready_i && !fifo_full;
        cmd_fire                  = s_cmd_valid_o && s_cmd_ready_i;
    end

    // Responses go only to the master at the FIFO head; an empty FIFO refuses the slave.
    always_comb begin
        m_rsp_valid_o             = '0;
        m_rsp_valid_o[head]       = !rst && s_rsp_valid_i && !fifo_empty;
        s_rsp_ready_o             = !rst && m_rsp_ready_i[head] && !fifo_empty;
        rsp_fire                  = s_rsp_valid_i && s_rsp_ready_o;
        m_rsp_rdata_o             = s_rsp_rdata_i;
        m_rsp_err_o               = s_rsp_err_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_fire) begin
                        grant_q <= gnt;
                        len_q   <= cur_len;
                        if (cur_len == '0) begin
                            rr_ptr_q <= gnt_nxt;
                        end else begin
                            state_q    <= BURST;
                            beat_cnt_q <= ICB_LEN_W'(1);
                        end
                    end
                end
                BURST: begin
                    if (cmd_fire) begin
                        if (beat_cnt_q == len_q) begin
                            state_q    <= IDLE;
                            rr_ptr_q   <= gnt_nxt;
                            beat_cnt_q <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    icb_id_fifo #(
        .DEPTH (OUTS),
        .W     (GW)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_fire),
        .pop_i   (rsp_fire),
        .din_i   (gnt),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A slave response with nothing outstanding is a protocol violation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(s_rsp_valid_i && fifo_empty));
        end
    end

endmodule
